pc_fetch_ctrl: RTL and testbench

- Fetch sequencer for the PC register in the multi-cycle CPU.
- Drives PC write-enable, PCsrc and Branch to the PC register.
- Runs a req/ack handshake to a variable-latency instruction memory and presents fetched instructions to decode with valid/ready.
- Discards wrong-path fetches on redirect, supports halt, and keeps fetch/kill statistics counters.

---
 rtl/pc_fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives PC write controls, runs the imem req/ack
// handshake and hands fetched words to decode over valid/ready.
module pc_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32,
  parameter int KILL_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_we,
  output logic [2:0]        pc_src,
  output logic              branch_out,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  input  logic              id_ready,
  input  logic              redir_valid,
  input  logic [2:0]        redir_src,
  input  logic              redir_taken,
  input  logic              halt,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [KILL_W-1:0] kill_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_KILL,
    S_HOLD,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_instr;
  logic [CNT_W-1:0]    r_icnt;
  logic [KILL_W-1:0]   r_kcnt;

  logic w_eff_redir;
  logic w_ld_pc;
  logic w_ld_pc4;
  logic w_ld_instr;
  logic w_inc_instr;
  logic w_inc_kill;

  assign w_eff_redir = redir_valid &&
    ((redir_src == 3'd1) || (redir_src == 3'd2) ||
     ((redir_src == 3'd3) && redir_taken));

  assign imem_addr = r_addr;
  assign if_instr  = r_instr;
  assign instr_cnt = r_icnt;
  assign kill_cnt  = r_kcnt;

  always_comb begin
    w_next      = r_state;
    pc_we       = 1'b0;
    pc_src      = 3'd0;
    branch_out  = 1'b0;
    imem_req    = 1'b0;
    if_valid    = 1'b0;
    halted      = 1'b0;
    w_ld_pc     = 1'b0;
    w_ld_pc4    = 1'b0;
    w_ld_instr  = 1'b0;
    w_inc_instr = 1'b0;
    w_inc_kill  = 1'b0;
    if (w_eff_redir) begin
      pc_we      = 1'b1;
      pc_src     = redir_src;
      branch_out = (redir_src == 3'd3);
    end
    unique case (r_state)
      S_IDLE: begin
        // PC changes on a redirect edge, so launch next cycle instead
        if (!w_eff_redir) begin
          if (halt) begin
            w_next = S_HALT;
          end else begin
            w_next  = S_FETCH;
            w_ld_pc = 1'b1;
          end
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack && !w_eff_redir) begin
          w_next     = S_HOLD;
          w_ld_instr = 1'b1;
        end else if (imem_ack) begin
          w_next     = S_IDLE;
          w_inc_kill = 1'b1;
        end else if (w_eff_redir) begin
          w_next = S_KILL;
        end
      end
      S_KILL: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_next     = S_IDLE;
          w_inc_kill = 1'b1;
        end
      end
      S_HOLD: begin
        if_valid = 1'b1;
        if (w_eff_redir) begin
          w_next     = S_IDLE;
          w_inc_kill = 1'b1;
        end else if (id_ready) begin
          pc_we       = 1'b1;
          w_inc_instr = 1'b1;
          if (halt) begin
            w_next = S_IDLE;
          end else begin
            w_next   = S_FETCH;
            w_ld_pc4 = 1'b1;
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (!halt) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (Reset) begin
      w_next      = S_IDLE;
      pc_we       = 1'b0;
      pc_src      = 3'd0;
      branch_out  = 1'b0;
      imem_req    = 1'b0;
      if_valid    = 1'b0;
      halted      = 1'b0;
      w_ld_pc     = 1'b0;
      w_ld_pc4    = 1'b0;
      w_ld_instr  = 1'b0;
      w_inc_instr = 1'b0;
      w_inc_kill  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_instr <= '0;
      r_icnt  <= '0;
      r_kcnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_ld_pc)     r_addr  <= pc_in;
      if (w_ld_pc4)    r_addr  <= pc_in + ADDR_W'(4);
      if (w_ld_instr)  r_instr <= imem_rdata;
      if (w_inc_instr) r_icnt  <= r_icnt + CNT_W'(1);
      if (w_inc_kill)  r_kcnt  <= r_kcnt + KILL_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: linear steps, inputs driven 1ns
// after each rising edge, outputs checked 1ns later.
module tb_pc_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] pc_in;
  logic        pc_we;
  logic [2:0]  pc_src;
  logic        branch_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        id_ready;
  logic        redir_valid;
  logic [2:0]  redir_src;
  logic        redir_taken;
  logic        halt;
  logic        halted;
  logic [31:0] instr_cnt;
  logic [15:0] kill_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .pc_in(pc_in),
    .pc_we(pc_we), .pc_src(pc_src), .branch_out(branch_out),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
    .redir_valid(redir_valid), .redir_src(redir_src),
    .redir_taken(redir_taken), .halt(halt), .halted(halted),
    .instr_cnt(instr_cnt), .kill_cnt(kill_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; pc_in = '0; imem_ack = 1'b0; imem_rdata = '0;
    id_ready = 1'b0; redir_valid = 1'b0; redir_src = 3'd0;
    redir_taken = 1'b0; halt = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_req",   64'(imem_req), 64'd0);
    chk("rst_pcwe",  64'(pc_we), 64'd0);
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_halted",64'(halted), 64'd0);
    chk("rst_addr",  64'(imem_addr), 64'd0);
    chk("rst_instr", 64'(if_instr), 64'd0);
    chk("rst_icnt",  64'(instr_cnt), 64'd0);
    chk("rst_kcnt",  64'(kill_cnt), 64'd0);
    Reset = 1'b0; id_ready = 1'b1;
    #1;
    chk("c1_idle_req", 64'(imem_req), 64'd0);
    // back-to-back zero-wait fetches from 0
    tick(); imem_ack = 1'b1; imem_rdata = 32'h1111_0000; #1;
    chk("f0_req",  64'(imem_req), 64'd1);
    chk("f0_addr", 64'(imem_addr), 64'h0);
    tick(); imem_ack = 1'b0; #1;
    chk("h0_valid", 64'(if_valid), 64'd1);
    chk("h0_instr", 64'(if_instr), 64'h1111_0000);
    chk("h0_pcwe",  64'(pc_we), 64'd1);
    chk("h0_pcsrc", 64'(pc_src), 64'd0);
    tick(); pc_in = 32'h4; imem_ack = 1'b1; imem_rdata = 32'h1111_0001; #1;
    chk("f1_addr", 64'(imem_addr), 64'h4);
    tick(); imem_ack = 1'b0; #1;
    chk("h1_pcwe", 64'(pc_we), 64'd1);
    tick(); pc_in = 32'h8; imem_ack = 1'b1; imem_rdata = 32'h1111_0002; #1;
    chk("f2_addr", 64'(imem_addr), 64'h8);
    tick(); imem_ack = 1'b0; #1;
    chk("h2_instr", 64'(if_instr), 64'h1111_0002);
    // delayed ack, stalled decode
    tick(); pc_in = 32'hC; id_ready = 1'b0; #1;
    chk("t1_icnt", 64'(instr_cnt), 64'd3);
    chk("w0_req",  64'(imem_req), 64'd1);
    chk("w0_addr", 64'(imem_addr), 64'hC);
    tick(); #1;
    chk("w1_req",  64'(imem_req), 64'd1);
    chk("w1_addr", 64'(imem_addr), 64'hC);
    tick(); #1;
    chk("w2_addr", 64'(imem_addr), 64'hC);
    tick(); imem_ack = 1'b1; imem_rdata = 32'h2222_0003; #1;
    chk("w3_valid", 64'(if_valid), 64'd0);
    tick(); imem_ack = 1'b0; #1;
    chk("s0_valid", 64'(if_valid), 64'd1);
    chk("s0_pcwe",  64'(pc_we), 64'd0);
    tick(); #1;
    chk("s1_instr", 64'(if_instr), 64'h2222_0003);
    chk("s1_pcwe",  64'(pc_we), 64'd0);
    tick(); id_ready = 1'b1; #1;
    chk("s2_pcwe", 64'(pc_we), 64'd1);
    // jr redirect in first FETCH cycle, late ack is killed
    tick(); pc_in = 32'h10; redir_valid = 1'b1; redir_src = 3'd2; #1;
    chk("r0_pcwe",  64'(pc_we), 64'd1);
    chk("r0_pcsrc", 64'(pc_src), 64'd2);
    chk("r0_br",    64'(branch_out), 64'd0);
    tick(); pc_in = 32'h100; redir_valid = 1'b0; #1;
    chk("k0_req",  64'(imem_req), 64'd1);
    chk("k0_addr", 64'(imem_addr), 64'h10);
    tick(); #1;
    tick(); imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("k2_valid", 64'(if_valid), 64'd0);
    tick(); imem_ack = 1'b0; #1;
    chk("k3_valid", 64'(if_valid), 64'd0);
    chk("k3_req",   64'(imem_req), 64'd0);
    chk("k3_kcnt",  64'(kill_cnt), 64'd1);
    chk("k3_instr", 64'(if_instr), 64'h2222_0003);
    tick(); imem_ack = 1'b1; imem_rdata = 32'h3333_0004; #1;
    chk("n0_addr", 64'(imem_addr), 64'h100);
    // taken branch while held, decode ready same cycle
    tick(); imem_ack = 1'b0; redir_valid = 1'b1; redir_src = 3'd3;
    redir_taken = 1'b1; #1;
    chk("b0_pcwe",  64'(pc_we), 64'd1);
    chk("b0_pcsrc", 64'(pc_src), 64'd3);
    chk("b0_br",    64'(branch_out), 64'd1);
    tick(); pc_in = 32'h200; redir_valid = 1'b0; redir_taken = 1'b0; #1;
    chk("b1_valid", 64'(if_valid), 64'd0);
    chk("b1_icnt",  64'(instr_cnt), 64'd4);
    chk("b1_kcnt",  64'(kill_cnt), 64'd2);
    // not-taken branch and illegal codes are ignored
    tick(); redir_valid = 1'b1; redir_src = 3'd3; imem_ack = 1'b1;
    imem_rdata = 32'h4444_0005; #1;
    chk("nt_addr", 64'(imem_addr), 64'h200);
    chk("nt_pcwe", 64'(pc_we), 64'd0);
    tick(); imem_ack = 1'b0; redir_src = 3'd4; id_ready = 1'b0; #1;
    chk("nt_valid", 64'(if_valid), 64'd1);
    chk("nt_instr", 64'(if_instr), 64'h4444_0005);
    chk("c4_pcwe",  64'(pc_we), 64'd0);
    chk("c4_kcnt",  64'(kill_cnt), 64'd2);
    tick(); redir_valid = 1'b0; id_ready = 1'b1; #1;
    chk("nt_hand", 64'(pc_we), 64'd1);
    // halt raised mid-fetch still completes handoff
    tick(); pc_in = 32'h204; halt = 1'b1; #1;
    chk("hf_req",  64'(imem_req), 64'd1);
    chk("hf_addr", 64'(imem_addr), 64'h204);
    tick(); imem_ack = 1'b1; imem_rdata = 32'h5555_0006; #1;
    tick(); imem_ack = 1'b0; #1;
    chk("hh_valid",  64'(if_valid), 64'd1);
    chk("hh_halted", 64'(halted), 64'd0);
    chk("hh_pcwe",   64'(pc_we), 64'd1);
    tick(); pc_in = 32'h208; #1;
    chk("hi_req", 64'(imem_req), 64'd0);
    chk("hi_icnt", 64'(instr_cnt), 64'd6);
    tick(); redir_valid = 1'b1; redir_src = 3'd1; #1;
    chk("ht_halted", 64'(halted), 64'd1);
    chk("ht_req",    64'(imem_req), 64'd0);
    chk("ht_pcwe",   64'(pc_we), 64'd1);
    chk("ht_pcsrc",  64'(pc_src), 64'd1);
    tick(); pc_in = 32'h300; redir_valid = 1'b0; halt = 1'b0; #1;
    chk("hx_halted", 64'(halted), 64'd1);
    tick(); #1;
    chk("hx_idle_req", 64'(imem_req), 64'd0);
    chk("hx_idle_hlt", 64'(halted), 64'd0);
    tick(); #1;
    chk("hx_req",  64'(imem_req), 64'd1);
    chk("hx_addr", 64'(imem_addr), 64'h300);
    // reset mid-fetch, late ack ignored, then wrap of pc+4
    Reset = 1'b1; #1;
    chk("mr_req",  64'(imem_req), 64'd0);
    chk("mr_pcwe", 64'(pc_we), 64'd0);
    tick(); Reset = 1'b0; pc_in = 32'hFFFF_FFFC; imem_ack = 1'b1;
    imem_rdata = 32'h0BAD_0BAD; #1;
    chk("mr_addr",  64'(imem_addr), 64'h0);
    chk("mr_instr", 64'(if_instr), 64'h0);
    chk("mr_icnt",  64'(instr_cnt), 64'd0);
    chk("mr_kcnt",  64'(kill_cnt), 64'd0);
    chk("mr_ireq",  64'(imem_req), 64'd0);
    tick(); imem_rdata = 32'h6666_0007; #1;
    chk("mf_valid", 64'(if_valid), 64'd0);
    chk("mf_addr",  64'(imem_addr), 64'hFFFF_FFFC);
    tick(); imem_ack = 1'b0; #1;
    chk("mf_instr", 64'(if_instr), 64'h6666_0007);
    tick(); #1;
    chk("wrap_addr", 64'(imem_addr), 64'h0);
    chk("wrap_icnt", 64'(instr_cnt), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
